btn_debounce: RTL

//   Input conditioner upstream of the IO-fabric demo core. Synchronises raw

---
 rtl/btn_debounce.sv | 66 ++++++
 1 files changed

// File: rtl/btn_debounce.sv
// Per-channel button conditioner: 2-FF synchroniser, stable-count debounce, edge pulses, toggle.
// Latency: a clean change on raw_in appears on level_out DEBOUNCE_CYCLES+2 edges later.
// No backpressure: free-running, every output is registered and valid every cycle.
module btn_debounce #(
  parameter int WIDTH           = 9,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] toggle_out
);

  // Count value at which a pending change is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            s1;
  logic [WIDTH-1:0]            s2;
  logic [WIDTH-1:0][CNT_W-1:0] cnt;

  // Two-stage synchroniser for the asynchronous pins; only s2 is used downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Per-channel stability counter, accepted level, edge pulses and toggle state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      level_out  <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      toggle_out <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rise_pulse[i] <= 1'b0;
        fall_pulse[i] <= 1'b0;
        if (s2[i] == level_out[i]) begin
          // Any return to the current level discards the pending change.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          level_out[i]  <= s2[i];
          cnt[i]        <= '0;
          rise_pulse[i] <= s2[i];
          fall_pulse[i] <= ~s2[i];
          if (s2[i]) begin
            toggle_out[i] <= ~toggle_out[i];
          end
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule
